bias_loader: RTL and testbench
==============================

Name: bias_loader

Overview:
- Writer side of the bias-weight memory: accepts bias words one at a time over a valid/ready stream (from the off-chip weight loader / testbench feeder).
- Assembles the words into a shadow vector of NUM_FEATURES+1 signed entries, then commits the whole vector with a single active-low write strobe.
- Sits between the weight-stream source and the bias memory inside the CNN top level; bias_WrEn and bias_weights_input connect port-for-port to the memory.

Parameters:
- NUM_FEATURES, 3, number of output features; vector holds NUM_FEATURES+1 entries (index 0..NUM_FEATURES). CNN top overrides it.
- DATA_WIDTH, 8, width of each signed bias word.

Ports:
- clk  input  1  single system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a load; honoured only in IDLE.
- abort  input  1  synchronous cancel of an in-progress load.
- in_valid  input  1  in_data/in_last valid.
- in_ready  output  1  loader accepts a word this cycle.
- in_data  input  DATA_WIDTH signed  bias word.
- in_last  input  1  marks final word of the vector.
- bias_weights_input  output  DATA_WIDTH signed x [NUM_FEATURES+1]  shadow vector to memory.
- bias_WrEn  output  1  write strobe to memory, active-low.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after a successful commit.
- len_err  output  1  sticky; set on in_last/length mismatch, cleared by next accepted start.

Behaviour:
- Reset (async, rst=0): state=IDLE, word count=0, all shadow entries 0, bias_WrEn=1, in_ready=0, busy=0, done=0, len_err=0. rst asserted mid-COMMIT forces bias_WrEn high immediately; no partial write is guaranteed beyond what the memory already sampled.
- All outputs registered; no combinational path from inputs to outputs.
- Word counter width max(1, $clog2(NUM_FEATURES+1)).
- States:
  - IDLE: in_ready=0. start=1 -> LOAD, count<=0, len_err<=0. Shadow contents retained, not cleared.
  - LOAD: in_ready=1. Handshake = in_valid & in_ready. On handshake, shadow[count]<=in_data and count++.
    - If count==NUM_FEATURES and in_last=1 -> COMMIT.
    - If in_last=1 with count<NUM_FEATURES (early last), or count==NUM_FEATURES with in_last=0 (missing last): word is written to shadow, len_err<=1, -> IDLE, no commit.
    - abort=1 -> IDLE, no commit; abort takes priority over a same-cycle handshake, so that word is dropped.
    - start is ignored.
  - COMMIT: in_ready=0, bias_WrEn=0 for exactly one clock period (posedge to posedge), so exactly one negedge lands inside the strobe. Shadow vector is stable throughout. abort is ignored. -> DONE.
  - DONE: bias_WrEn=1, done=1 for one cycle -> IDLE.
- Latency: final accepted word at posedge N -> bias_WrEn low during cycle N+1, done high during cycle N+2, busy low from N+3. Earliest next start is cycle N+3.
- in_ready deasserts the cycle after the final handshake; no extra word is ever accepted.
- bias_weights_input continuously reflects shadow, including during LOAD. This is harmless because the memory only samples while bias_WrEn=0.
- Sign preserved bit-exact; no arithmetic is performed on data.

Test Plan:
- Reset: hold rst=0 with random inputs -> bias_WrEn=1, in_ready=0, busy=0, done=0, len_err=0, all entries 0.
- Back-to-back load (NUM_FEATURES=3, DATA_WIDTH=8): start, then words -5,3,127,-128 on 4 consecutive cycles, in_last on the 4th -> in_ready high exactly 4 cycles, bias_WrEn low exactly 1 cycle the next cycle, done pulse the cycle after. An attached bias memory then reads {-5,3,127,-128}.
- Gapped stream: same data with in_valid deasserted for 2 cycles between words -> identical commit values, single WrEn pulse, no duplicate or skipped entries.
- Early in_last on the 2nd word -> len_err=1, bias_WrEn never low, returns to IDLE. A new start clears len_err; a subsequent full load of 1,2,3,4 commits correctly.
- abort asserted together with the 3rd handshake -> no WrEn pulse, IDLE next cycle. Following full load of 10,20,30,40 -> memory reads {10,20,30,40}. start pulsed during LOAD -> ignored.
- Async reset: rst dropped mid-cycle while bias_WrEn=0 in COMMIT -> bias_WrEn=1 without waiting for a clock edge. After release, state is IDLE and no done pulse occurs.

Source files
------------

// File: rtl/bias_loader.sv
// Bias-weight writer: gathers streamed bias words into a shadow vector
// and commits the whole vector to the bias memory with one low strobe.
module bias_loader #(
    parameter int NUM_FEATURES = 3,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_last,
    output logic signed [DATA_WIDTH-1:0] bias_weights_input [NUM_FEATURES+1],
    output logic                         bias_WrEn,
    output logic                         busy,
    output logic                         done,
    output logic                         len_err
);

    localparam int CW = (NUM_FEATURES > 0) ? $clog2(NUM_FEATURES + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_FEATURES);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT,
        DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   count;

    // The output vector is the shadow register itself, so it is visible
    // during LOAD; the memory only samples it while bias_WrEn is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            count     <= '0;
            in_ready  <= 1'b0;
            bias_WrEn <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            len_err   <= 1'b0;
            for (int i = 0; i <= NUM_FEATURES; i++) begin
                bias_weights_input[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        count    <= '0;
                        len_err  <= 1'b0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                LOAD: begin
                    // abort wins over a same-cycle handshake: the word is dropped
                    if (abort) begin
                        state    <= IDLE;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                    end else if (in_valid) begin
                        bias_weights_input[count] <= in_data;
                        count <= count + 1'b1;
                        if (count == LAST && in_last) begin
                            state     <= COMMIT;
                            in_ready  <= 1'b0;
                            bias_WrEn <= 1'b0;
                        end else if (count == LAST || in_last) begin
                            state    <= IDLE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            len_err  <= 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    state     <= DONE;
                    bias_WrEn <= 1'b1;
                    done      <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bias_loader.sv
// Directed bench for bias_loader: vector table plus multi-cycle sequences,
// with a negedge-sampling bias memory model on the write strobe.
module tb_bias_loader;

    logic              clk;
    logic              rst;
    logic              start;
    logic              abort;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] in_data;
    logic              in_last;
    logic signed [7:0] bias_weights_input [4];
    logic              bias_WrEn;
    logic              busy;
    logic              done;
    logic              len_err;

    int checks;
    int errors;
    int strobes;
    logic [31:0] mem;

    bias_loader #(.NUM_FEATURES(3), .DATA_WIDTH(8)) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .abort              (abort),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_data            (in_data),
        .in_last            (in_last),
        .bias_weights_input (bias_weights_input),
        .bias_WrEn          (bias_WrEn),
        .busy               (busy),
        .done               (done),
        .len_err            (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bias memory model: samples the vector on negedges inside the strobe
    always @(negedge clk) begin
        if (bias_WrEn === 1'b0) begin
            mem <= {bias_weights_input[3], bias_weights_input[2],
                    bias_weights_input[1], bias_weights_input[0]};
            strobes <= strobes + 1;
        end
    end

    typedef struct {
        logic              st;
        logic              ab;
        logic              v;
        logic signed [7:0] d;
        logic              l;
        logic              r;
        logic              w;
        logic              b;
        logic              dn;
        logic              e;
        logic              chk;
        logic [31:0]       m;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic st, input logic ab, input logic v,
                                input int d, input logic l,
                                input logic r, input logic w, input logic b,
                                input logic dn, input logic e,
                                input logic chk, input logic [31:0] m);
        vec_t x;
        x.st = st; x.ab = ab; x.v = v; x.d = 8'(d); x.l = l;
        x.r = r; x.w = w; x.b = b; x.dn = dn; x.e = e;
        x.chk = chk; x.m = m;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        start = 0; abort = 0; in_valid = 0; in_data = 0; in_last = 0;
    endtask

    initial begin
        int s0;
        int w[4];
        checks = 0; errors = 0; strobes = 0; mem = '0;

        // Reset held with random inputs
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            start = 1'($urandom); abort = 1'($urandom);
            in_valid = 1'($urandom); in_data = 8'($urandom);
            in_last = 1'($urandom);
            tick();
        end
        check("rst_wren", bias_WrEn, 1);
        check("rst_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", len_err, 0);
        for (int k = 0; k < 4; k++)
            check($sformatf("rst_entry%0d", k), bias_weights_input[k], 0);
        idle_in();
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Back-to-back load
        vq.push_back(mk(1,0,0,   0,0, 1,1,1,0,0, 0,0));
        vq.push_back(mk(0,0,1,  -5,0, 1,1,1,0,0, 0,0));
        vq.push_back(mk(0,0,1,   3,0, 1,1,1,0,0, 0,0));
        vq.push_back(mk(0,0,1, 127,0, 1,1,1,0,0, 0,0));
        vq.push_back(mk(0,0,1,-128,1, 0,0,1,0,0, 0,0));
        vq.push_back(mk(0,0,0,   0,0, 0,1,1,1,0, 0,0));
        vq.push_back(mk(0,0,0,   0,0, 0,1,0,0,0, 1,32'h807F03FB));
        // Early in_last, then clean reload
        vq.push_back(mk(1,0,0,   0,0, 1,1,1,0,0, 0,0));
        vq.push_back(mk(0,0,1,   1,0, 1,1,1,0,0, 0,0));
        vq.push_back(mk(0,0,1,   2,1, 0,1,0,0,1, 0,0));
        vq.push_back(mk(0,0,0,   0,0, 0,1,0,0,1, 0,0));
        vq.push_back(mk(1,0,0,   0,0, 1,1,1,0,0, 0,0));
        vq.push_back(mk(0,0,1,   1,0, 1,1,1,0,0, 0,0));
        vq.push_back(mk(0,0,1,   2,0, 1,1,1,0,0, 0,0));
        vq.push_back(mk(0,0,1,   3,0, 1,1,1,0,0, 0,0));
        vq.push_back(mk(0,0,1,   4,1, 0,0,1,0,0, 0,0));
        vq.push_back(mk(0,0,0,   0,0, 0,1,1,1,0, 0,0));
        vq.push_back(mk(0,0,0,   0,0, 0,1,0,0,0, 1,32'h04030201));
        // Abort on 3rd handshake, then load with a stray start
        vq.push_back(mk(1,0,0,   0,0, 1,1,1,0,0, 0,0));
        vq.push_back(mk(0,0,1,   9,0, 1,1,1,0,0, 0,0));
        vq.push_back(mk(0,0,1,   8,0, 1,1,1,0,0, 0,0));
        vq.push_back(mk(0,1,1,   7,0, 0,1,0,0,0, 0,0));
        vq.push_back(mk(0,0,0,   0,0, 0,1,0,0,0, 1,32'h04030201));
        vq.push_back(mk(1,0,0,   0,0, 1,1,1,0,0, 0,0));
        vq.push_back(mk(0,0,1,  10,0, 1,1,1,0,0, 0,0));
        vq.push_back(mk(1,0,1,  20,0, 1,1,1,0,0, 0,0));
        vq.push_back(mk(0,0,1,  30,0, 1,1,1,0,0, 0,0));
        vq.push_back(mk(0,0,1,  40,1, 0,0,1,0,0, 0,0));
        vq.push_back(mk(0,0,0,   0,0, 0,1,1,1,0, 0,0));
        vq.push_back(mk(0,0,0,   0,0, 0,1,0,0,0, 1,32'h281E140A));
        // Missing in_last on the 4th word
        vq.push_back(mk(1,0,0,   0,0, 1,1,1,0,0, 0,0));
        vq.push_back(mk(0,0,1,   5,0, 1,1,1,0,0, 0,0));
        vq.push_back(mk(0,0,1,   6,0, 1,1,1,0,0, 0,0));
        vq.push_back(mk(0,0,1,   7,0, 1,1,1,0,0, 0,0));
        vq.push_back(mk(0,0,1,   8,0, 0,1,0,0,1, 0,0));
        vq.push_back(mk(0,0,0,   0,0, 0,1,0,0,1, 1,32'h281E140A));

        for (int i = 0; i < vq.size(); i++) begin
            start = vq[i].st; abort = vq[i].ab; in_valid = vq[i].v;
            in_data = vq[i].d; in_last = vq[i].l;
            tick();
            check($sformatf("row%0d ready", i), in_ready, vq[i].r);
            check($sformatf("row%0d wren", i), bias_WrEn, vq[i].w);
            check($sformatf("row%0d busy", i), busy, vq[i].b);
            check($sformatf("row%0d done", i), done, vq[i].dn);
            check($sformatf("row%0d err", i), len_err, vq[i].e);
            if (vq[i].chk)
                check($sformatf("row%0d mem", i), mem, vq[i].m);
        end
        idle_in();
        check("table_strobes", strobes, 3);
        check("shadow_after_missing_last",
              {bias_weights_input[3], bias_weights_input[2],
               bias_weights_input[1], bias_weights_input[0]}, 32'h08070605);

        // Gapped stream
        w[0] = -5; w[1] = 3; w[2] = 127; w[3] = -128;
        s0 = strobes;
        start = 1; tick(); start = 0;
        check("gap_start_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_data = 8'(w[i]); in_last = (i == 3);
            tick();
            in_valid = 0; in_last = 0; in_data = 8'h55;
            if (i < 3) begin
                for (int g = 0; g < 2; g++) begin
                    tick();
                    check($sformatf("gap%0d_%0d ready", i, g), in_ready, 1);
                    check($sformatf("gap%0d_%0d wren", i, g), bias_WrEn, 1);
                end
            end
        end
        check("gap_commit_wren", bias_WrEn, 0);
        check("gap_commit_ready", in_ready, 0);
        tick();
        check("gap_done", done, 1);
        check("gap_done_wren", bias_WrEn, 1);
        tick();
        check("gap_idle_busy", busy, 0);
        check("gap_mem", mem, 32'h807F03FB);
        check("gap_strobes", strobes, s0 + 1);

        // Async reset while the strobe is low
        s0 = strobes;
        start = 1; tick(); start = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_data = 8'(i + 1); in_last = (i == 3);
            tick();
        end
        idle_in();
        check("ar_commit_wren", bias_WrEn, 0);
        #3;
        rst = 1'b0;
        #1;
        check("ar_wren_async", bias_WrEn, 1);
        check("ar_busy", busy, 0);
        check("ar_ready", in_ready, 0);
        check("ar_entry0", bias_weights_input[0], 0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("ar_post%0d done", k), done, 0);
            check($sformatf("ar_post%0d busy", k), busy, 0);
            check($sformatf("ar_post%0d wren", k), bias_WrEn, 1);
        end
        check("ar_strobes", strobes, s0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got 0 expected 1");
        $fatal(1);
    end

endmodule
